// File: rtl/uart_reg_bridge_pkg.sv
// Shared encodings for the UART register bridge: state codes, protocol bytes
// and helpers that build the response shift-register image.
package uart_bridge_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR    = 4'd1,
    S_DATA    = 4'd2,
    S_WRITE   = 4'd3,
    S_READ    = 4'd4,
    S_SEND    = 4'd5,
    S_WAIT_HI = 4'd6,
    S_WAIT_LO = 4'd7
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  localparam int BYTE_TMR_W = 22;
  localparam int READ_TMR_W = 8;
  localparam int RESP_W     = 40;

  // Responses are left-aligned so the head byte always sits in [39:32].
  function automatic logic [RESP_W-1:0] rsp_single(input logic [7:0] b);
    return {b, 32'h0000_0000};
  endfunction

  function automatic logic [RESP_W-1:0] rsp_read(input logic [31:0] d);
    return {RSP_OK, d};
  endfunction

endpackage

// File: rtl/uart_reg_bridge_tx_sequencer.sv
// Response buffer and UART transmit handshake: sends len bytes MSB-first,
// one tx_start per byte, waiting for tx_busy to rise and fall in between.
module uart_tx_sequencer
  import uart_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [RESP_W-1:0] load_data,
  input  logic [2:0]        load_len,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              done
);

  state_t            phase_p0;
  state_t            phase_next;
  logic [RESP_W-1:0] resp_buf_p0;
  logic [2:0]        resp_len_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_p0    <= S_IDLE;
      resp_buf_p0 <= '0;
      resp_len_p0 <= '0;
    end else begin
      phase_p0 <= phase_next;
      if (load) begin
        resp_buf_p0 <= load_data;
        resp_len_p0 <= load_len;
      end else if (phase_p0 == S_WAIT_LO && !tx_busy) begin
        resp_buf_p0 <= {resp_buf_p0[RESP_W-9:0], 8'h00};
        resp_len_p0 <= resp_len_p0 - 3'd1;
      end
    end
  end

  always_comb begin
    phase_next = phase_p0;
    tx_start   = 1'b0;
    done       = 1'b0;
    case (phase_p0)
      S_IDLE:    if (load) phase_next = S_SEND;
      S_SEND: begin
        if (!tx_busy) begin
          tx_start   = 1'b1;
          phase_next = S_WAIT_HI;
        end
      end
      S_WAIT_HI: if (tx_busy) phase_next = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!tx_busy) begin
          // Length counts the byte just finished, so 1 means this was the last.
          if (resp_len_p0 <= 3'd1) begin
            done       = 1'b1;
            phase_next = S_IDLE;
          end else begin
            phase_next = S_SEND;
          end
        end
      end
      default:   phase_next = S_IDLE;
    endcase
  end

  // Buffer only shifts after tx_busy falls, so the head byte is stable while sending.
  assign tx_data = resp_buf_p0[RESP_W-1:RESP_W-8];

endmodule

// File: rtl/uart_reg_bridge.sv
// Serial register protocol target: parses 'W'/'R' frames from the UART,
// drives single-cycle register bus strobes and queues the reply bytes.
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int BYTE_TIMEOUT = 2500000,
  parameter int READ_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_error,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [31:0] reg_rdata,
  input  logic        reg_rvalid,
  output logic        frame_error,
  output logic        busy
);

  localparam logic [BYTE_TMR_W-1:0] BYTE_LIMIT = BYTE_TMR_W'(BYTE_TIMEOUT - 1);
  localparam logic [READ_TMR_W-1:0] READ_LIMIT = READ_TMR_W'(READ_TIMEOUT);

  state_t                state_p0;
  state_t                state_next;
  logic                  is_write_p0;
  logic [1:0]            byte_cnt_p0;
  logic [BYTE_TMR_W-1:0] byte_tmr_p0;
  logic [READ_TMR_W-1:0] read_tmr_p0;

  logic                  rx_byte;
  logic                  load;
  logic [RESP_W-1:0]     load_data;
  logic [2:0]            load_len;
  logic                  seq_done;

  // A byte arriving together with a framing error is not a byte.
  assign rx_byte = rx_valid && !rx_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= S_IDLE;
      is_write_p0 <= 1'b0;
      byte_cnt_p0 <= '0;
      byte_tmr_p0 <= '0;
      read_tmr_p0 <= '0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_re      <= 1'b0;
    end else begin
      state_p0 <= state_next;
      reg_re   <= 1'b0;
      if (state_p0 == S_IDLE && rx_byte)
        is_write_p0 <= (rx_data == CMD_WRITE);
      if (rx_valid || !(state_p0 inside {S_ADDR, S_DATA}))
        byte_tmr_p0 <= '0;
      else
        byte_tmr_p0 <= byte_tmr_p0 + 1'b1;
      if (state_p0 == S_ADDR && rx_byte) begin
        reg_addr    <= rx_data;
        byte_cnt_p0 <= 2'd3;
        reg_re      <= !is_write_p0;
      end
      if (state_p0 == S_DATA && rx_byte) begin
        reg_wdata   <= {reg_wdata[23:0], rx_data};
        byte_cnt_p0 <= byte_cnt_p0 - 2'd1;
      end
      // The reg_re cycle itself is not counted, so rvalid is accepted up to READ_TIMEOUT after it.
      if (state_p0 != S_READ)
        read_tmr_p0 <= '0;
      else if (!reg_re && read_tmr_p0 != READ_LIMIT)
        read_tmr_p0 <= read_tmr_p0 + 1'b1;
    end
  end

  always_comb begin
    state_next  = state_p0;
    load        = 1'b0;
    load_data   = '0;
    load_len    = '0;
    reg_we      = 1'b0;
    frame_error = 1'b0;
    case (state_p0)
      S_IDLE: begin
        if (rx_byte) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            state_next = S_ADDR;
          end else begin
            load       = 1'b1;
            load_data  = rsp_single(RSP_ERR);
            load_len   = 3'd1;
            state_next = S_SEND;
          end
        end
      end
      S_ADDR, S_DATA: begin
        if (rx_error) begin
          frame_error = 1'b1;
          state_next  = S_IDLE;
        end else if (rx_valid) begin
          if (state_p0 == S_ADDR)
            state_next = is_write_p0 ? S_DATA : S_READ;
          else if (byte_cnt_p0 == 2'd0)
            state_next = S_WRITE;
        end else if (byte_tmr_p0 == BYTE_LIMIT) begin
          frame_error = 1'b1;
          state_next  = S_IDLE;
        end
      end
      S_WRITE: begin
        reg_we      = 1'b1;
        frame_error = rx_valid;
        load        = 1'b1;
        load_data   = rsp_single(RSP_OK);
        load_len    = 3'd1;
        state_next  = S_SEND;
      end
      S_READ: begin
        frame_error = rx_valid;
        if (reg_rvalid) begin
          load       = 1'b1;
          load_data  = rsp_read(reg_rdata);
          load_len   = 3'd5;
          state_next = S_SEND;
        end else if (read_tmr_p0 == READ_LIMIT) begin
          frame_error = 1'b1;
          load        = 1'b1;
          load_data   = rsp_single(RSP_ERR);
          load_len    = 3'd1;
          state_next  = S_SEND;
        end
      end
      S_SEND: begin
        frame_error = rx_valid;
        if (seq_done) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state_p0 != S_IDLE);

  uart_tx_sequencer u_tx_seq (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_len  (load_len),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .done      (seq_done)
  );

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge with a protocol-level expectation model,
// a UART transmitter model and a register-bus responder.
module tb_uart_reg_bridge;

  localparam int BT = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_error = 1'b0;
  logic        tx_busy = 1'b0;
  logic [31:0] reg_rdata = 32'h0;
  logic        reg_rvalid = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic        frame_error;
  logic        busy;

  uart_reg_bridge #(.BYTE_TIMEOUT(BT), .READ_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid), .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  exp_tx[$];
  logic [39:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  tx_log[$];
  int tx_count = 0, we_count = 0, re_count = 0, fe_count = 0;
  int fe_cyc = 0, re_cyc = 0, we_cyc = 0, rv_cyc = 0, last_rx_cyc = 0;
  bit pend_we = 0, pend_rv = 0;
  int tx_len = 8;
  int rd_delay = 0;
  logic [31:0] rd_value = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    fails++;
    $display("FAIL %s: unexpected event, value %0h (cycle %0d)", name, act, cyc);
  endtask

  // Protocol model: what the bus and UART must see for one host frame.
  task automatic expect_frame(input logic [7:0] cmd, input logic [7:0] addr,
                              input logic [31:0] d, input int delay);
    if (cmd == 8'h57) begin
      exp_wr.push_back({addr, d});
      exp_tx.push_back(8'h4B);
    end else if (cmd == 8'h52) begin
      exp_rd.push_back(addr);
      if (delay >= 1 && delay <= 255) begin
        exp_tx.push_back(8'h4B);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(d[8*i +: 8]);
      end else begin
        exp_tx.push_back(8'h45);
      end
    end else begin
      exp_tx.push_back(8'h45);
    end
  endtask

  // Compare process: every strobe is checked against the model queues.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (rx_valid) last_rx_cyc = cyc;
      if (reg_rvalid) begin rv_cyc = cyc; pend_rv = 1; end
      if (frame_error) begin fe_count++; fe_cyc = cyc; end
      if (reg_we) begin
        we_count++;
        chk("we_re_exclusive", reg_re, 0);
        if (exp_wr.size() == 0) unexpected("reg_we", {reg_addr, reg_wdata});
        else chk("write_addr_data", {reg_addr, reg_wdata}, exp_wr.pop_front());
        chk("we_latency", cyc - last_rx_cyc, 1);
        we_cyc = cyc;
        pend_we = 1;
      end
      if (reg_re) begin
        re_count++;
        re_cyc = cyc;
        if (exp_rd.size() == 0) unexpected("reg_re", reg_addr);
        else chk("read_addr", reg_addr, exp_rd.pop_front());
      end
      if (tx_start) begin
        tx_count++;
        chk("tx_start_when_idle", tx_busy, 0);
        tx_log.push_back(tx_data);
        if (exp_tx.size() == 0) unexpected("tx_start", tx_data);
        else chk("tx_byte", tx_data, exp_tx.pop_front());
        if (pend_we) chk("we_to_tx_latency", cyc - we_cyc, 1);
        if (pend_rv) chk("rvalid_to_tx_latency", cyc - rv_cyc, 1);
        pend_we = 0;
        pend_rv = 0;
      end
    end
  end

  // UART transmitter: busy rises the cycle after an accepted tx_start.
  initial forever begin
    @(negedge clk);
    if (tx_start === 1'b1) begin
      @(posedge clk); #1 tx_busy = 1'b1;
      repeat (tx_len) @(posedge clk);
      #1 tx_busy = 1'b0;
    end
  end

  // Register responder: answers reg_re after rd_delay cycles (0 = never).
  initial forever begin
    @(negedge clk);
    if (reg_re === 1'b1 && !rst && rd_delay > 0) begin
      repeat (rd_delay) @(posedge clk);
      #1 reg_rvalid = 1'b1; reg_rdata = rd_value;
      @(posedge clk);
      #1 reg_rvalid = 1'b0; reg_rdata = 32'h0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(2);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(1); n++; end
    chk(name, busy, 0);
  endtask

  task automatic run_write(input logic [7:0] addr, input logic [31:0] d);
    expect_frame(8'h57, addr, d, 0);
    send_byte(8'h57);
    send_byte(addr);
    for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
  endtask

  task automatic run_read(input logic [7:0] addr, input logic [31:0] d, input int delay);
    rd_value = d;
    rd_delay = delay;
    expect_frame(8'h52, addr, d, delay);
    send_byte(8'h52);
    send_byte(addr);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {tx_start, reg_we, reg_re, frame_error, busy}, 0);
    chk("reset_regs", {reg_addr, reg_wdata, tx_data}, 0);
    @(posedge clk); #1 rst = 1'b0;
    tick(2);

    run_write(8'h10, 32'hDEADBEEF);
    wait_idle("write_idle", 200);
    chk("write_count", we_count, 1);
    chk("write_tx_literal", tx_log[0], 8'h4B);
    chk("write_wdata_held", reg_wdata, 32'hDEADBEEF);
    chk("write_queues_empty", exp_wr.size() + exp_tx.size(), 0);

    run_read(8'h22, 32'h12345678, 3);
    wait_idle("read_idle", 300);
    chk("read_tx_literal", {tx_log[1], tx_log[2], tx_log[3], tx_log[4], tx_log[5]}, 40'h4B12345678);
    chk("read_count", re_count, 1);
    chk("read_addr_held", reg_addr, 8'h22);

    expect_frame(8'h41, 8'h00, 32'h0, 0);
    send_byte(8'h41);
    wait_idle("badcmd_idle", 200);
    chk("badcmd_tx_literal", tx_log[6], 8'h45);
    chk("badcmd_no_we", we_count, 1);
    chk("badcmd_no_re", re_count, 1);
    chk("badcmd_no_fe", fe_count, 0);

    run_read(8'h33, 32'h0, 0);
    wait_idle("rto_idle", 600);
    chk("rto_fe_count", fe_count, 1);
    chk("rto_fe_latency", fe_cyc - re_cyc, 256);
    chk("rto_tx_literal", tx_log[7], 8'h45);

    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'hAA);
    wait_idle("bto_idle", 1000);
    chk("bto_fe_count", fe_count, 2);
    chk("bto_fe_latency", fe_cyc - last_rx_cyc, BT);
    chk("bto_no_tx", tx_count, 8);
    chk("bto_no_we", we_count, 1);
    run_read(8'h10, 32'hCAFEF00D, 1);
    wait_idle("post_bto_read_idle", 300);
    chk("post_bto_read_literal", {tx_log[8], tx_log[9], tx_log[10], tx_log[11], tx_log[12]}, 40'h4BCAFEF00D);

    send_byte(8'h57);
    send_byte(8'h10);
    rx_error = 1'b1;
    tick(1);
    rx_error = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_fe_count", fe_count, 3);
    tick(20);
    chk("abort_no_tx", tx_count, 13);

    run_read(8'h44, 32'hA1B2C3D4, 2);
    begin
      int n = 0;
      while (tx_count < 16 && n < 300) begin tick(1); n++; end
      chk("midsend_third_byte_started", tx_count, 16);
    end
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("midsend_reset_ctrl", {tx_start, reg_we, reg_re, frame_error, busy}, 0);
    chk("midsend_reset_regs", {reg_addr, reg_wdata, tx_data}, 0);
    rst = 1'b0;
    exp_tx.delete();
    tick(100);
    chk("midsend_no_more_tx", tx_count, 16);
    chk("midsend_sent_literal", {tx_log[13], tx_log[14], tx_log[15]}, 24'h4BA1B2);
    chk("final_bus_queues_empty", exp_wr.size() + exp_rd.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
- Byte-level command responder on the receive/transmit byte interface of the board UART.
- Parses host frames (register read/write), issues single-cycle register bus accesses, and returns response bytes through the UART transmit handshake.
- Sits between the UART and the control register file; it is the target end of the host's serial register protocol.

Parameters:
- BYTE_TIMEOUT, 2500000, clk cycles allowed between bytes inside a frame (100 ms at 25 MHz); counter is 22 bits.
- READ_TIMEOUT, 255, clk cycles allowed for reg_rvalid after reg_re; counter is 8 bits.

Ports:
- clk  in  1  master clock
- rst  in  1  synchronous reset, active-high
- rx_valid  in  1  one-cycle strobe; a byte has been received
- rx_data  in  8  received byte; valid when rx_valid=1
- rx_error  in  1  one-cycle strobe; UART framing error
- tx_start  out  1  one-cycle request to transmit tx_data
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_busy falls
- tx_busy  in  1  UART transmitter not idle; rises the cycle after an accepted tx_start
- reg_addr  out  8  register address
- reg_wdata  out  32  write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  32  read data; valid when reg_rvalid=1
- reg_rvalid  in  1  read data strobe, arriving 1..READ_TIMEOUT cycles after reg_re
- frame_error  out  1  one-cycle pulse: aborted frame, timeout or overrun
- busy  out  1  high whenever the state is not S_IDLE

Behaviour:
- Reset: all outputs are 0; state is S_IDLE; counters, address and data registers are cleared. Reset mid-frame or mid-send discards all state. An in-flight UART byte is not recalled.
- Frame format:
  - Write: 'W'(0x57), addr, d3, d2, d1, d0 (MSB first).
  - Read: 'R'(0x52), addr.
- Responses:
  - Write: 'K'(0x4B).
  - Read: 'K', d3, d2, d1, d0.
  - Bad command or read timeout: 'E'(0x45).
- States:
  - S_IDLE: on rx_valid, go to S_ADDR if the byte is 'W' or 'R' (latch is_write); otherwise load response 'E' and go to S_SEND.
  - S_ADDR: on rx_valid, latch reg_addr. Write goes to S_DATA with byte_cnt=3. Read goes to S_READ and asserts reg_re for exactly one cycle.
  - S_DATA: on rx_valid, shift the byte into reg_wdata[7:0] (left-shift by 8). At byte_cnt=0, go to S_WRITE; otherwise decrement byte_cnt.
  - S_WRITE: reg_we=1 for one cycle, load response 'K' (length 1), go to S_SEND.
  - S_READ: on reg_rvalid, load response {'K', rdata[31:24], [23:16], [15:8], [7:0]} (length 5) and go to S_SEND. If READ_TIMEOUT cycles pass without reg_rvalid, load 'E' and pulse frame_error.
  - S_SEND: if tx_busy=0, drive tx_data from the head of the response buffer, pulse tx_start, go to S_WAIT_HI.
  - S_WAIT_HI: wait for tx_busy=1.
  - S_WAIT_LO: wait for tx_busy=0; then shift the buffer and decrement resp_len. If resp_len=0 go to S_IDLE, else go to S_SEND.
- Response buffer: 40-bit shift register plus 3-bit resp_len.
- Inter-byte timeout: the counter is cleared on every rx_valid and only runs in S_ADDR and S_DATA. Reaching BYTE_TIMEOUT returns to S_IDLE, pulses frame_error, sends no response.
- rx_error in S_ADDR or S_DATA aborts the frame: return to S_IDLE, pulse frame_error. rx_error in S_IDLE is ignored.
- Overrun: rx_valid in S_WRITE, S_READ or any send state drops the byte and pulses frame_error; the current transaction still completes.
- Simultaneous rx_valid and rx_error: the error wins.
- Bus ordering: reg_we and reg_re never assert in the same cycle. reg_wdata and reg_addr hold their values until the next frame.
- Latency:
  - Last write byte to reg_we: 1 cycle.
  - reg_we to tx_start: 1 cycle.
  - reg_rvalid to tx_start: 1 cycle.

Decomposition:
- Package uart_bridge_pkg holds: state encoding localparams (4 bits); CMD_WRITE=0x57, CMD_READ=0x52, RSP_OK=0x4B, RSP_ERR=0x45.
- Sub-module uart_tx_sequencer owns the response buffer and the S_SEND/S_WAIT_HI/S_WAIT_LO handshake (load, len, done).
- The parser FSM stays in the top module.

Test Plan:
- Write: bytes 57 10 DE AD BE EF -> one reg_we pulse with addr=0x10, wdata=0xDEADBEEF; tx bytes 4B; busy falls afterwards.
- Read: bytes 52 22, responder returns 0x12345678 after 3 cycles -> one reg_re pulse with addr=0x22; tx bytes 4B 12 34 56 78 in order, each tx_start only while tx_busy=0.
- Bad command and read timeout: byte 41 -> tx 45, no bus strobes. Read with no reg_rvalid -> tx 45 plus one frame_error pulse, 256 cycles after reg_re.
- Inter-byte timeout: bytes 57 10 AA then silence -> frame_error after BYTE_TIMEOUT cycles, no reg_we, no tx. A following 52 10 reads correctly.
- Aborts: rx_error after 57 10 -> frame_error, state S_IDLE. rst asserted during the 3rd response byte of a read -> all outputs 0 the next cycle, remaining bytes never sent.
